serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
//
// PURPOSE
//   Serial receiver for the lab's single-wire link. It watches the serial
//   line `d`, detects and validates a start bit, then shifts in DATA_BITS
//   data bits LSB first and checks the stop bit. Each good frame is
//   presented on `q` with a one-cycle `valid` strobe. It is the receive end
//   of the serial stimulus the lab's flip-flop benches drive. It uses
//   synchronizer and shift flip-flops only, with no external baud tick.
//
// PARAMETERS
//   DATA_BITS     8   data bits per frame (1..16)
//   CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 4
//
// PORTS
//   clk       in   1          system clock, rising edge
//   resetBar  in   1          asynchronous reset, active-low
//   d         in   1          serial line; idles high; asynchronous to clk
//   q         out  DATA_BITS  last good frame's data, held until next good frame
//   valid     out  1          one-cycle strobe: q updated this cycle
//   frameErr  out  1          one-cycle strobe: stop bit sampled low
//   busy      out  1          high from start-bit detect until return to IDLE
//
// BEHAVIOUR
//   - Reset (resetBar low, async):
//     - q=0, valid=0, frameErr=0, busy=0, state=IDLE.
//     - Both synchronizer flops are set to 1 (line treated as idle).
//     - Counters are cleared.
//     - A mid-frame reset abandons the frame and produces no strobe.
//   - Input sync: 2-flop synchronizer on d. All logic below uses the
//     synchronized value ds.
//   - Bit timer: counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT).
//     The bit index counter is $clog2(DATA_BITS+1) wide.
//   - FSM states:
//     - IDLE: busy=0. On ds==0, clear the timer and go to START.
//     - START: wait (CLKS_PER_BIT/2)-1 cycles, then sample mid-bit.
//       - If ds==0, clear the timer, set bit index to 0, go to DATA.
//       - Otherwise treat it as a glitch and return to IDLE. No strobe.
//     - DATA: sample ds every CLKS_PER_BIT cycles, shifting it into the
//       shift register MSB, so bit 0 arrives first. After DATA_BITS samples
//       go to PAR if PARITY_CHECK_EN is defined, else to STOP.
//     - PAR: sample the parity bit one bit period later, then go to STOP.
//     - STOP: sample one bit period later.
//       - If ds==1 and no parity error, the frame is good: load q from the
//         shift register, pulse valid, go to IDLE.
//       - If ds==1 and a parity error was found, pulse the parity strobe,
//         leave q unchanged, go to IDLE.
//       - If ds==0, pulse frameErr, leave q unchanged, go to BREAK.
//     - BREAK: busy=1. Wait for ds==1, then go to IDLE. A stuck-low line
//       therefore cannot retrigger start detection.
//   - Latency: valid rises on the clk edge after the mid-stop-bit sample.
//     Measured from the line's falling start edge, that is about
//     (DATA_BITS+1.5)*CLKS_PER_BIT + 3 cycles, including 2 cycles of
//     synchronizer delay.
//   - Strobes are exactly one cycle wide and never overlap each other.
//   - Back-to-back frames: a new start edge is accepted in the very next
//     IDLE cycle after a STOP sample. Minimum frame spacing is 0 idle bits.
//   - Data changing on d between sample points is ignored. Each bit is
//     taken from a single mid-bit sample; there is no majority vote.
//
// CONFIGURATION
//   PARITY_CHECK_EN
//     Defined:
//       - An even-parity bit follows the data bits, and the PAR state is
//         enabled.
//       - Adds port parityErr (out, 1 bit): a one-cycle strobe at STOP
//         when the XOR of data and parity is 1. Reset value is 0.
//       - A parity-failed frame does not assert valid.
//       - If the same frame also has a bad stop bit, frameErr takes
//         precedence and parityErr stays 0.
//     Undefined:
//       - No PAR state and no parityErr port.
//       - Frame is 1 start + DATA_BITS data + 1 stop.
//
// TESTING  (CLKS_PER_BIT=16, DATA_BITS=8, 20 ns clk)
//   1. resetBar=0 for 40 ns, then 1. Line idles high.
//      -> q=8'h00, valid=frameErr=busy=0.
//   2. Send 0xA5: start 0, bits 1,0,1,0,0,1,0,1, stop 1.
//      -> exactly one valid pulse and q=8'hA5.
//      -> busy returns to 0 in the same cycle; q is held afterwards.
//   3. Pull the line low for 4 clk, then release it.
//      -> no valid/frameErr; busy returns to 0 at the mid-start sample.
//   4. Send 0x3C with the stop bit held low, release the line 3 bits later.
//      -> frameErr pulses once; q stays 8'hA5.
//      -> busy stays high until the line goes high.
//   5. Assert resetBar=0 during data bit 4 of a frame, then send 0x81.
//      -> no strobe for the aborted frame; q=0 after reset.
//      -> the next frame gives q=8'h81 with valid.
//   6. With PARITY_CHECK_EN: send 0x07 with parity 1, then 0x07 with
//      parity 0.
//      -> first frame: valid and q=8'h07.
//      -> second frame: parityErr pulses; q is unchanged and there is no
//         valid.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receive end of the lab's single-wire serial link. The line is brought
//   into the clk domain through a 2-flop synchronizer, a start bit is
//   validated at its midpoint, DATA_BITS data bits are shifted in LSB first
//   (one mid-bit sample each), and the stop bit is checked. Good frames are
//   presented on q with a one-cycle valid strobe.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   -> an even-parity bit follows the data bits; adds parityErr
//     undefined -> frame is start + DATA_BITS data + stop, no parityErr port
//
//   Ports
//     clk        in   system clock, rising edge
//     resetBar   in   asynchronous reset, active-low
//     d          in   serial line, idles high, asynchronous to clk
//     q          out  data of the last good frame, held until the next one
//     valid      out  one-cycle strobe, q updated this cycle
//     frameErr   out  one-cycle strobe, stop bit sampled low
//     busy       out  high from start detect until the FSM is back in IDLE
//     parityErr  out  one-cycle strobe, parity mismatch (PARITY_CHECK_EN only)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line idle, waiting for ds low
//   START  | timing to the middle of the start bit to confirm it
//   DATA   | sampling DATA_BITS data bits, one per bit period
//   PAR    | sampling the parity bit
//   STOP   | sampling the stop bit, issuing the frame result strobe
//   BREAK  | stop bit was low; wait for the line to return high

module serial_frame_receiver #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 resetBar,
    input  logic                 d,
    output logic [DATA_BITS-1:0] q,
    output logic                 valid,
    output logic                 frameErr,
    output logic                 busy
`ifdef PARITY_CHECK_EN
    ,
    output logic                 parityErr
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic                   ds;
    logic [TW-1:0]          timer_q, timer_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   bit_done;
    logic                   mid_start;
`ifdef PARITY_CHECK_EN
    logic                   par_acc_q, par_acc_d;
    logic                   parity_err_q, parity_err_d;
`endif

    // Both sync flops reset high so the line reads idle out of reset.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign ds        = sync2_q;
    assign bit_done  = (timer_q == TW'(CLKS_PER_BIT - 1));
    assign mid_start = (timer_q == TW'(CLKS_PER_BIT / 2 - 1));

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
`ifdef PARITY_CHECK_EN
            par_acc_q    <= par_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_acc_d    = par_acc_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!ds) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (mid_start) begin
                    timer_d = '0;
                    if (!ds) begin
                        bit_idx_d = '0;
`ifdef PARITY_CHECK_EN
                        par_acc_d = 1'b0;
`endif
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    // New bit enters at the MSB so bit 0 ends up at the LSB.
                    shift_d                = shift_q >> 1;
                    shift_d[DATA_BITS-1]   = ds;
`ifdef PARITY_CHECK_EN
                    par_acc_d = par_acc_q ^ ds;
`endif
                    if (bit_idx_q == BW'(DATA_BITS - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end

            S_PAR: begin
                if (bit_done) begin
                    timer_d = '0;
`ifdef PARITY_CHECK_EN
                    par_acc_d = par_acc_q ^ ds;
`endif
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (ds) begin
`ifdef PARITY_CHECK_EN
                        if (par_acc_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shift_q;
                        valid_d = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        // A low stop bit outranks any parity result.
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                timer_d = '0;
                if (ds) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign q        = data_q;
    assign valid    = valid_q;
    assign frameErr = frame_err_q;
    assign busy     = (state_q != S_IDLE);
`ifdef PARITY_CHECK_EN
    assign parityErr = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;

    localparam int DB = 8;
    localparam int C  = 16;
`ifdef PARITY_CHECK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // Falling start edge to strobe: (DB+1.5) bit periods + 3 cycles,
    // plus one more bit period when a parity bit is present.
    localparam int LAT = ((2 * DB + 3) * C) / 2 + 3 + PB * C;

    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 4;

    typedef struct {
        int            kind;
        logic [DB-1:0] data;
        int            t0;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetBar = 1'b0;
    logic          d = 1'b1;
    logic [DB-1:0] q;
    logic          valid;
    logic          frameErr;
    logic          busy;
    logic          parityErr;

    exp_t          sb[$];
    exp_t          e_mon;
    logic [2:0]    sv;
    logic [DB-1:0] q_model = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    serial_frame_receiver #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk      (clk),
        .resetBar (resetBar),
        .d        (d),
        .q        (q),
        .valid    (valid),
        .frameErr (frameErr),
        .busy     (busy)
`ifdef PARITY_CHECK_EN
        ,
        .parityErr(parityErr)
`endif
    );

`ifndef PARITY_CHECK_EN
    assign parityErr = 1'b0;
`endif

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding frame in
    // kind, arrival cycle, busy level and the q value the model holds.
    always @(negedge clk) begin
        if (resetBar) begin
            sv = {parityErr, frameErr, valid};
            if (sv != 3'b000) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_strobe", 32'(sv), 32'd0);
                end else begin
                    e_mon = sb.pop_front();
                    check_eq("strobe_kind", 32'(sv), 32'(e_mon.kind));
                    check_eq("strobe_time", 32'(cyc - e_mon.t0), 32'(LAT));
                    if (e_mon.kind == K_VALID) q_model = e_mon.data;
                    check_eq("busy_at_strobe", 32'(busy), 32'(e_mon.kind == K_FERR));
                    check_eq("q_at_strobe", 32'(q), 32'(q_model));
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        d = b;
        repeat (C) @(negedge clk);
    endtask

    // Called on a negedge. stop_ok=0 holds the line low for the stop bit
    // plus hold_bits more bit periods before releasing it.
    task automatic send_frame(input logic [DB-1:0] data, input bit stop_ok,
                              input int hold_bits, input bit par_ok);
        exp_t e;
        logic par;
        par = (^data) ^ !par_ok;
        if (!stop_ok)                  e.kind = K_FERR;
        else if (PB == 1 && !par_ok)   e.kind = K_PERR;
        else                           e.kind = K_VALID;
        e.data = data;
        e.t0   = cyc;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(data[i]);
        if (PB == 1) drive_bit(par);
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            drive_bit(1'b0);
            repeat (hold_bits) drive_bit(1'b0);
            check_eq("busy_in_break", 32'(busy), 32'd1);
            d = 1'b1;
            repeat (4) @(negedge clk);
            check_eq("busy_after_break", 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: time limit reached, %0d frames outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] rd;
        resetBar = 1'b0;
        d        = 1'b1;
        repeat (2) @(negedge clk);
        resetBar = 1'b1;
        @(negedge clk);
        check_eq("rst_q", 32'(q), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_frameErr", 32'(frameErr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        repeat (C) @(negedge clk);

        // Good frame 0xA5.
        send_frame(8'hA5, 1'b1, 0, 1'b1);
        wait_drain(4 * C);
        repeat (2 * C) @(negedge clk);
        check_eq("q_hold_a5", 32'(q), 32'hA5);

        // Short low glitch: rejected at mid-start.
        d = 1'b0;
        repeat (4) @(negedge clk);
        d = 1'b1;
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (C / 2 + 2) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy), 32'd0);
        repeat (C) @(negedge clk);

        // Stop bit held low, line released 3 bits later.
        send_frame(8'h3C, 1'b0, 2, 1'b1);
        wait_drain(4 * C);
        check_eq("q_after_ferr", 32'(q), 32'hA5);
        repeat (C) @(negedge clk);

        // Reset in the middle of data bit 4.
        rd = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rd[i]);
        d = rd[4];
        repeat (C / 2) @(negedge clk);
        resetBar = 1'b0;
        q_model  = '0;
        repeat (2) @(negedge clk);
        d = 1'b1;
        check_eq("midrst_q", 32'(q), 32'h00);
        resetBar = 1'b1;
        repeat (2 * C) @(negedge clk);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_q_idle", 32'(q), 32'h00);
        send_frame(8'h81, 1'b1, 0, 1'b1);
        wait_drain(4 * C);

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b1, 0, 1'b1);
        send_frame(8'h07, 1'b1, 0, 1'b0);
        wait_drain(4 * C);
        check_eq("q_after_perr", 32'(q), 32'h07);
`endif

        // Random frames with 0..2 idle bits between them (0 = back-to-back).
        for (int n = 0; n < 24; n++) begin
            send_frame(DB'($urandom_range(0, 255)),
                       ($urandom_range(0, 5) != 0),
                       int'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
        end
        wait_drain(4 * C);
        repeat (C) @(negedge clk);
        check_eq("final_q", 32'(q), 32'(q_model));
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
